carrier_wipeoff_accum: RTL and testbench
========================================

# carrier_wipeoff_accum

Carrier wipe-off and integrate-and-dump stage of the GPS tracking channel. It sits directly downstream of the carrier NCO. It multiplies each incoming IF sample by the NCO's 3-bit sine/cosine to form baseband I/Q products, then accumulates them over one integration period of INT_LEN valid samples. Each completed I/Q sum is presented to the discriminator/loop-filter stage through a valid/ready handshake.

## Interface
- INT_LEN, 4092: valid samples per integration period (1 ms at 4.092 MS/s); legal range 2..65535.
- ACC_W, 20: accumulator and output width, signed.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sample_valid  in  1  qualifies sample/sine/cosine/epoch this cycle.
- sample  in  3  signed IF sample, range -4..3.
- sine  in  3  signed NCO sine, already time-aligned to sample by the caller.
- cosine  in  3  signed NCO cosine, aligned as sine.
- epoch  in  1  code-epoch restart; honoured only with sample_valid.
- dump_valid  out  1  i_sum/q_sum/dump_seq hold a completed integration.
- dump_ready  in  1  consumer accepts the dump on a cycle where dump_valid is high.
- i_sum  out  ACC_W  signed in-phase integration result.
- q_sum  out  ACC_W  signed quadrature integration result.
- dump_seq  out  16  sequence number of the presented dump; wraps at 65535 to 0.
- sat  out  1  the presented dump saturated in I or Q.
- overrun  out  1  one-cycle pulse when an unaccepted dump is overwritten.

## Operation
- Mixing per valid sample: pi = sample*cosine, pq = -(sample*sine).
  - Products are 7-bit signed with no truncation; the negation is exact.
- Products are sign-extended to ACC_W and added to the running sums.
  - Each add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Once a sum clips, a per-period sat flag sets and holds until period end.
- Sample counter 0..INT_LEN-1 advances only on sample_valid. Gaps in sample_valid stall everything and lose nothing.
- On the valid sample with count = INT_LEN-1 (final sample):
  - The final sums, including that sample, load the output registers.
  - dump_seq increments and dump_valid sets.
  - Accumulators and the sat flag restart from zero, so the next valid sample is sample 0 of the new period.
- epoch && sample_valid:
  - The partial sums are discarded with no dump.
  - The counter restarts, and this sample becomes sample 0.
  - If this is also the final sample, epoch wins and no dump is produced.
- Handshake:
  - A transfer occurs at any edge where dump_valid && dump_ready.
  - dump_valid clears after a transfer unless a new dump loads at the same edge; it then stays high with the new data and overrun is not raised.
- New dump while dump_valid && !dump_ready at the load edge:
  - The new values overwrite the held ones (newest wins) and dump_valid stays high.
  - overrun pulses for one cycle.
  - dump_seq still increments, so the consumer sees the gap.
- Reset clears every register:
  - i_sum=0, q_sum=0, dump_seq=0, sat=0, dump_valid=0, overrun=0.
  - Counter, accumulators and the product pipeline are cleared.
  - A reset mid-period discards that period; the first dump after release needs a full INT_LEN valid samples.

## Timing
- Stage 1 registers pi/pq plus the valid, final and epoch tags. Stage 2 accumulates and loads the dump.
- Final sample presented in cycle n → dump_valid, i_sum, q_sum, dump_seq, sat valid in cycle n+2.
- An overrun pulse occurs in the same cycle n+2.
- Throughput: one sample per cycle, with no bubbles at the period boundary.
- Outputs are registered; there is no combinational path from dump_ready to any output.

## Structure
- Shared package gps_pkg holds:
  - typedef nco_t (logic signed [2:0]) and sample_t (logic signed [2:0]).
  - Constants GPS_INT_LEN_DEFAULT = 4092 and SAMPLE_W = 3.
- Sub-module iq_mixer is the stage-1 complex multiply and register, with a valid passthrough. The top level holds the counter, saturating accumulators and the dump/handshake register.

## Test plan
- Constant input, INT_LEN=8, sample=3, cosine=3, sine=0, continuous valid → i_sum=72, q_sum=0, sat=0, dump_seq=1, dump_valid 2 cycles after the 8th sample.
- sample=-4, sine=-3, cosine=0, INT_LEN=8 → q_sum=-96, i_sum=0. Insert random sample_valid gaps → identical result, with dump timing relative to the 8th valid sample.
- dump_ready=0 across two periods → one overrun pulse when the second dump loads. Outputs show the second period's sums, and dump_seq goes 1→2 with no handshake at 1. Raising dump_ready at the load edge of a third dump → no overrun, dump_valid stays high.
- INT_LEN=8, epoch with the 6th valid sample → no dump. The next dump covers exactly 8 samples starting at the epoch sample. Epoch on a would-be final sample → no dump.
- ACC_W=8, INT_LEN=16, sample=3, cosine=3 → i_sum=127, sat=1. The next period with sample=0 → i_sum=0, sat=0.
- Assert rst for 1 cycle after 5 valid samples → all outputs 0 immediately. The first dump occurs after INT_LEN valid samples post-release, with dump_seq=1.

Source files
------------

// File: rtl/gps_pkg.sv
// Shared GPS tracking-channel types and constants: 3-bit IF samples and NCO outputs,
// plus the default integration length.
package gps_pkg;
  localparam int SAMPLE_W            = 3;
  localparam int GPS_INT_LEN_DEFAULT = 4092;
  localparam int PROD_W              = 2 * SAMPLE_W + 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [2:0]          nco_t;
endpackage

// File: rtl/carrier_wipeoff_accum_if.sv
// Sample input and dump valid/ready bundle for the wipe-off/accumulate stage;
// mst is the producer/consumer side, slv is the block side.
interface carrier_wipeoff_accum_if
  import gps_pkg::*;
#(
  parameter int ACC_W = 20
);
  logic                    sample_valid;
  sample_t                 sample;
  nco_t                    sine;
  nco_t                    cosine;
  logic                    epoch;
  logic                    dump_valid;
  logic                    dump_ready;
  logic signed [ACC_W-1:0] i_sum;
  logic signed [ACC_W-1:0] q_sum;
  logic [15:0]             dump_seq;
  logic                    sat;
  logic                    overrun;

  modport mst (
    output sample_valid, sample, sine, cosine, epoch, dump_ready,
    input  dump_valid, i_sum, q_sum, dump_seq, sat, overrun
  );

  modport slv (
    input  sample_valid, sample, sine, cosine, epoch, dump_ready,
    output dump_valid, i_sum, q_sum, dump_seq, sat, overrun
  );
endinterface

// File: rtl/iq_mixer.sv
// Stage 1: exact complex wipe-off pi = s*cos, pq = -(s*sin), registered with valid and tags.
// One cycle latency, no backpressure (the stage always accepts).
module iq_mixer
  import gps_pkg::*;
#(
  parameter int TAG_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  input  logic [TAG_W-1:0]         in_tag,
  input  sample_t                  sample,
  input  nco_t                     sine,
  input  nco_t                     cosine,
  output logic                     out_vld,
  output logic [TAG_W-1:0]         out_tag,
  output logic signed [PROD_W-1:0] pi,
  output logic signed [PROD_W-1:0] pq
);
  logic signed [PROD_W-1:0] ps;
  logic signed [PROD_W-1:0] pi_d, pi_q;
  logic signed [PROD_W-1:0] pq_d, pq_q;
  logic                     vld_d, vld_q;
  logic [TAG_W-1:0]         tag_d, tag_q;

  // 7 bits hold every product of two 3-bit signed values, including -(-4*-4) = -16.
  always_comb begin
    ps    = PROD_W'(sample) * PROD_W'(sine);
    pi_d  = PROD_W'(sample) * PROD_W'(cosine);
    pq_d  = -ps;
    vld_d = in_vld;
    tag_d = in_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pi_q  <= '0;
      pq_q  <= '0;
      vld_q <= 1'b0;
      tag_q <= '0;
    end else begin
      pi_q  <= pi_d;
      pq_q  <= pq_d;
      vld_q <= vld_d;
      tag_q <= tag_d;
    end
  end

  assign pi      = pi_q;
  assign pq      = pq_q;
  assign out_vld = vld_q;
  assign out_tag = tag_q;
endmodule

// File: rtl/carrier_wipeoff_accum.sv
// Carrier wipe-off plus saturating integrate-and-dump over INT_LEN valid samples; dump 2 cycles
// after the final sample; a held dump is overwritten (newest wins) with an overrun pulse.
module carrier_wipeoff_accum
  import gps_pkg::*;
#(
  parameter int INT_LEN = GPS_INT_LEN_DEFAULT,
  parameter int ACC_W   = 20
) (
  input logic                    clk,
  input logic                    rst,
  carrier_wipeoff_accum_if.slv   bus
);
  localparam logic [15:0]      LAST    = 16'(INT_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [15:0]              cnt_d, cnt_q;
  logic                     is_final;
  logic                     p_vld;
  logic [1:0]               p_tag;
  logic signed [PROD_W-1:0] p_i, p_q;

  // Epoch wins over the final sample: it restarts the period with this sample as sample 0.
  assign is_final = bus.sample_valid && !bus.epoch && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.sample_valid) begin
      if (bus.epoch)          cnt_d = 16'd1;
      else if (cnt_q == LAST) cnt_d = 16'd0;
      else                    cnt_d = cnt_q + 16'd1;
    end
  end

  iq_mixer #(.TAG_W(2)) u_mixer (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (bus.sample_valid),
    .in_tag  ({is_final, bus.epoch}),
    .sample  (bus.sample),
    .sine    (bus.sine),
    .cosine  (bus.cosine),
    .out_vld (p_vld),
    .out_tag (p_tag),
    .pi      (p_i),
    .pq      (p_q)
  );

  // Returns {clipped, saturated sum}.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + (ACC_W+1)'(p);
    if (s[ACC_W] != s[ACC_W-1]) return {1'b1, (s[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  logic signed [ACC_W-1:0] i_acc_d, i_acc_q, q_acc_d, q_acc_q;
  logic                    sat_acc_d, sat_acc_q;
  logic signed [ACC_W-1:0] i_sum_d, i_sum_q, q_sum_d, q_sum_q;
  logic [15:0]             dump_seq_d, dump_seq_q;
  logic                    sat_d, sat_q;
  logic                    dump_valid_d, dump_valid_q;
  logic                    overrun_d, overrun_q;
  logic signed [ACC_W-1:0] i_base, q_base;
  logic [ACC_W:0]          i_new, q_new;
  logic                    sat_new;

  always_comb begin
    i_acc_d      = i_acc_q;
    q_acc_d      = q_acc_q;
    sat_acc_d    = sat_acc_q;
    i_sum_d      = i_sum_q;
    q_sum_d      = q_sum_q;
    dump_seq_d   = dump_seq_q;
    sat_d        = sat_q;
    dump_valid_d = dump_valid_q;
    overrun_d    = 1'b0;

    // An epoch sample starts the sums afresh rather than adding to the partial period.
    i_base  = p_tag[0] ? '0 : i_acc_q;
    q_base  = p_tag[0] ? '0 : q_acc_q;
    i_new   = sat_add(i_base, p_i);
    q_new   = sat_add(q_base, p_q);
    sat_new = (sat_acc_q && !p_tag[0]) || i_new[ACC_W] || q_new[ACC_W];

    if (dump_valid_q && bus.dump_ready) dump_valid_d = 1'b0;

    if (p_vld) begin
      if (p_tag[1]) begin
        i_sum_d      = i_new[ACC_W-1:0];
        q_sum_d      = q_new[ACC_W-1:0];
        sat_d        = sat_new;
        dump_seq_d   = dump_seq_q + 16'd1;
        dump_valid_d = 1'b1;
        overrun_d    = dump_valid_q && !bus.dump_ready;
        i_acc_d      = '0;
        q_acc_d      = '0;
        sat_acc_d    = 1'b0;
      end else begin
        i_acc_d   = i_new[ACC_W-1:0];
        q_acc_d   = q_new[ACC_W-1:0];
        sat_acc_d = sat_new;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      i_acc_q      <= '0;
      q_acc_q      <= '0;
      sat_acc_q    <= 1'b0;
      i_sum_q      <= '0;
      q_sum_q      <= '0;
      dump_seq_q   <= '0;
      sat_q        <= 1'b0;
      dump_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      i_acc_q      <= i_acc_d;
      q_acc_q      <= q_acc_d;
      sat_acc_q    <= sat_acc_d;
      i_sum_q      <= i_sum_d;
      q_sum_q      <= q_sum_d;
      dump_seq_q   <= dump_seq_d;
      sat_q        <= sat_d;
      dump_valid_q <= dump_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.i_sum      = i_sum_q;
  assign bus.q_sum      = q_sum_q;
  assign bus.dump_seq   = dump_seq_q;
  assign bus.sat        = sat_q;
  assign bus.dump_valid = dump_valid_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_carrier_wipeoff_accum.sv
// Directed bench: dut_a (INT_LEN=8, ACC_W=20) for mixing, gaps, epoch, overrun and reset;
// dut_b (INT_LEN=16, ACC_W=8) for saturation. Inputs change and outputs are sampled on negedge.
module tb_carrier_wipeoff_accum;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   seq_a  = 0;

  carrier_wipeoff_accum_if #(.ACC_W(20)) ifa ();
  carrier_wipeoff_accum_if #(.ACC_W(8))  ifb ();

  carrier_wipeoff_accum #(.INT_LEN(8),  .ACC_W(20)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  carrier_wipeoff_accum #(.INT_LEN(16), .ACC_W(8))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int     s;
    int     sn;
    int     c;
    longint exp_i;
    longint exp_q;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic put_a(input logic v, input int s, input int sn, input int c, input logic ep);
    ifa.sample_valid = v;
    ifa.sample       = 3'(s);
    ifa.sine         = 3'(sn);
    ifa.cosine       = 3'(c);
    ifa.epoch        = ep;
    @(negedge clk);
  endtask

  task automatic put_b(input logic v, input int s, input int sn, input int c);
    ifb.sample_valid = v;
    ifb.sample       = 3'(s);
    ifb.sine         = 3'(sn);
    ifb.cosine       = 3'(c);
    ifb.epoch        = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_a(input int n);
    repeat (n) put_a(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic run_a(input int n, input int s, input int sn, input int c);
    repeat (n) put_a(1'b1, s, sn, c, 1'b0);
  endtask

  task automatic chk_dump_a(input string nm, input longint ei, input longint eq, input longint es);
    chk({nm, ".valid"}, longint'(ifa.dump_valid), 1);
    chk({nm, ".i"},     longint'(ifa.i_sum), ei);
    chk({nm, ".q"},     longint'(ifa.q_sum), eq);
    chk({nm, ".seq"},   longint'(ifa.dump_seq), es);
  endtask

  task automatic chk_dump_b(input string nm, input longint ei, input longint esat, input longint es);
    chk({nm, ".valid"}, longint'(ifb.dump_valid), 1);
    chk({nm, ".i"},     longint'(ifb.i_sum), ei);
    chk({nm, ".q"},     longint'(ifb.q_sum), 0);
    chk({nm, ".sat"},   longint'(ifb.sat), esat);
    chk({nm, ".seq"},   longint'(ifb.dump_seq), es);
  endtask

  vec_t   vecs[5];
  logic   early;
  longint seq0;

  initial begin
    rst = 1'b1;
    ifa.dump_ready = 1'b1;
    ifb.dump_ready = 1'b1;
    ifb.sample_valid = 1'b0;
    ifb.sample = '0; ifb.sine = '0; ifb.cosine = '0; ifb.epoch = 1'b0;
    idle_a(2);
    chk("rst.valid",   longint'(ifa.dump_valid), 0);
    chk("rst.i",       longint'(ifa.i_sum), 0);
    chk("rst.q",       longint'(ifa.q_sum), 0);
    chk("rst.seq",     longint'(ifa.dump_seq), 0);
    chk("rst.sat",     longint'(ifa.sat), 0);
    chk("rst.overrun", longint'(ifa.overrun), 0);
    rst = 1'b0;
    idle_a(1);

    // pi = s*c, pq = -(s*sn), summed over 8 samples
    vecs[0] = '{s: 3,  sn: 0,  c: 3,  exp_i: 72,  exp_q: 0};
    vecs[1] = '{s: -4, sn: -3, c: 0,  exp_i: 0,   exp_q: -96};
    vecs[2] = '{s: -4, sn: 3,  c: -4, exp_i: 128, exp_q: 96};
    vecs[3] = '{s: 1,  sn: -4, c: -4, exp_i: -32, exp_q: 32};
    vecs[4] = '{s: 3,  sn: 3,  c: 3,  exp_i: 72,  exp_q: -72};
    for (int k = 0; k < 5; k++) begin
      run_a(8, vecs[k].s, vecs[k].sn, vecs[k].c);
      chk($sformatf("vec%0d.lat", k), longint'(ifa.dump_valid), 0);
      idle_a(1);
      seq_a++;
      chk_dump_a($sformatf("vec%0d", k), vecs[k].exp_i, vecs[k].exp_q, seq_a);
      chk($sformatf("vec%0d.sat", k), longint'(ifa.sat), 0);
      idle_a(1);
      chk($sformatf("vec%0d.clear", k), longint'(ifa.dump_valid), 0);
    end

    // Random gaps with junk inputs (including epoch) while sample_valid is low
    early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) begin
        put_a(1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        early = early | ifa.dump_valid;
      end
      put_a(1'b1, -4, -3, 0, 1'b0);
      if (k < 7) early = early | ifa.dump_valid;
    end
    chk("gap.early", longint'(early | ifa.dump_valid), 0);
    idle_a(1);
    seq_a++;
    chk_dump_a("gap", 0, -96, seq_a);
    idle_a(1);

    // Overrun: two dumps with no handshake, then ready rises on the third load edge
    ifa.dump_ready = 1'b0;
    run_a(8, 3, 0, 3);
    idle_a(1);
    seq_a++;
    chk_dump_a("ovr1", 72, 0, seq_a);
    chk("ovr1.overrun", longint'(ifa.overrun), 0);
    run_a(8, 1, 1, 1);
    chk("ovr2.hold_i", longint'(ifa.i_sum), 72);
    idle_a(1);
    seq_a++;
    chk_dump_a("ovr2", 8, -8, seq_a);
    chk("ovr2.overrun", longint'(ifa.overrun), 1);
    idle_a(1);
    chk("ovr2.pulse_end", longint'(ifa.overrun), 0);
    chk("ovr2.still_valid", longint'(ifa.dump_valid), 1);
    run_a(8, 2, 0, 1);
    ifa.dump_ready = 1'b1;
    idle_a(1);
    seq_a++;
    chk_dump_a("ovr3", 16, 0, seq_a);
    chk("ovr3.overrun", longint'(ifa.overrun), 0);
    idle_a(1);
    chk("ovr3.clear", longint'(ifa.dump_valid), 0);

    // Epoch on the 6th valid sample discards 5 samples; period restarts at the epoch sample
    seq0 = seq_a;
    run_a(5, 1, 0, 1);
    put_a(1'b1, 2, 0, 1, 1'b1);
    run_a(6, 2, 0, 1);
    idle_a(2);
    chk("ep6.nodump_seq", longint'(ifa.dump_seq), seq0);
    chk("ep6.nodump_vld", longint'(ifa.dump_valid), 0);
    run_a(1, 2, 0, 1);
    idle_a(1);
    seq_a++;
    chk_dump_a("ep6", 16, 0, seq_a);
    idle_a(1);

    // Epoch on a would-be final sample suppresses the dump
    seq0 = seq_a;
    run_a(7, 1, 0, 1);
    put_a(1'b1, 2, 0, 1, 1'b1);
    idle_a(2);
    chk("ep8.nodump_seq", longint'(ifa.dump_seq), seq0);
    run_a(7, 2, 0, 1);
    idle_a(1);
    seq_a++;
    chk_dump_a("ep8", 16, 0, seq_a);
    idle_a(1);

    // Saturation on the narrow instance: 16*9 = 144 clips to 127, 16*-12 = -192 clips to -128
    repeat (16) put_b(1'b1, 3, 0, 3);
    put_b(1'b0, 0, 0, 0);
    chk_dump_b("satp", 127, 1, 1);
    repeat (16) put_b(1'b1, 0, 0, 3);
    put_b(1'b0, 0, 0, 0);
    chk_dump_b("sat0", 0, 0, 2);
    repeat (16) put_b(1'b1, -4, 0, 3);
    put_b(1'b0, 0, 0, 0);
    chk_dump_b("satn", -128, 1, 3);
    put_b(1'b0, 0, 0, 0);

    // One-cycle reset after 5 valid samples clears outputs at once and discards the period
    run_a(5, 1, 0, 1);
    rst = 1'b1;
    #1;
    chk("mrst.i",     longint'(ifa.i_sum), 0);
    chk("mrst.seq",   longint'(ifa.dump_seq), 0);
    chk("mrst.valid", longint'(ifa.dump_valid), 0);
    chk("mrst.sat",   longint'(ifb.sat), 0);
    idle_a(1);
    rst = 1'b0;
    run_a(7, 3, 0, 3);
    idle_a(2);
    chk("mrst.early_seq", longint'(ifa.dump_seq), 0);
    run_a(1, 3, 0, 3);
    idle_a(1);
    chk_dump_a("mrst", 72, 0, 1);
    idle_a(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
